// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO controller: per-pin direction, atomic set/clear, synchronised
// inputs and edge-triggered, write-1-to-clear interrupt status.

module gpio_pin #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_in,
    input  logic irq_en,
    input  logic rising,
    output logic level,
    output logic hit
);
    logic [SYNC_STAGES-1:0] chain;
    logic                   prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin_in};
            prev  <= chain[SYNC_STAGES-1];
        end
    end

    assign level = chain[SYNC_STAGES-1];
    assign hit   = irq_en & (rising ? (level & ~prev) : (~level & prev));
endmodule

module gpio_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       addr,
    input  logic             we,
    input  logic [31:0]      di,
    output logic [31:0]      dout,
    inout  wire  [WIDTH-1:0] pins,
    output logic             irq
);
    localparam logic [2:0] A_DATA_OUT   = 3'd0;
    localparam logic [2:0] A_DIR        = 3'd1;
    localparam logic [2:0] A_DATA_IN    = 3'd2;
    localparam logic [2:0] A_IRQ_EN     = 3'd3;
    localparam logic [2:0] A_IRQ_EDGE   = 3'd4;
    localparam logic [2:0] A_IRQ_STATUS = 3'd5;
    localparam logic [2:0] A_SET        = 3'd6;
    localparam logic [2:0] A_CLR        = 3'd7;

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_edge;
    logic [WIDTH-1:0] irq_status;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] hit;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd;

    // Bits above WIDTH are dropped on write.
    assign wdata = di[WIDTH-1:0];
    logic unused_di;
    assign unused_di = ^di;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign pins[i] = dir[i] ? data_out[i] : 1'bz;

        gpio_pin #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .clk    (clk),
            .reset  (reset),
            .pin_in (pins[i]),
            .irq_en (irq_en[i]),
            .rising (irq_edge[i]),
            .level  (data_in[i]),
            .hit    (hit[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
            dir      <= '0;
            irq_en   <= '0;
            irq_edge <= '0;
        end else if (we) begin
            case (addr)
                A_DATA_OUT: data_out <= wdata;
                A_DIR:      dir      <= wdata;
                A_IRQ_EN:   irq_en   <= wdata;
                A_IRQ_EDGE: irq_edge <= wdata;
                A_SET:      data_out <= data_out | wdata;
                A_CLR:      data_out <= data_out & ~wdata;
                default:    ;
            endcase
        end
    end

    assign w1c = (we && addr == A_IRQ_STATUS) ? wdata : '0;

    // OR-ing hit after the clear makes a same-cycle event win over W1C.
    always_ff @(posedge clk) begin
        if (reset) irq_status <= '0;
        else       irq_status <= (irq_status & ~w1c) | hit;
    end

    assign irq = |irq_status;

    always_comb begin
        rd = '0;
        case (addr)
            A_DATA_OUT:   rd = data_out;
            A_DIR:        rd = dir;
            A_DATA_IN:    rd = data_in;
            A_IRQ_EN:     rd = irq_en;
            A_IRQ_EDGE:   rd = irq_edge;
            A_IRQ_STATUS: rd = irq_status;
            default:      rd = '0;
        endcase
        dout = 32'(rd);
    end
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl; stimulus queues expectations, a negedge monitor checks them.

module tb_gpio_ctrl;
    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] di = '0;
    wire  [31:0] dout;
    wire  [W-1:0] pins;
    wire         irq;

    logic [W-1:0] ext_drv = '0;
    logic [W-1:0] ext_en = '1;

    always #5 clk = ~clk;

    for (genvar g = 0; g < W; g++) begin : g_ext
        assign pins[g] = ext_en[g] ? ext_drv[g] : 1'bz;
    end

    gpio_ctrl #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .di    (di),
        .dout  (dout),
        .pins  (pins),
        .irq   (irq)
    );

    localparam int K_DOUT = 0;
    localparam int K_IRQ  = 1;
    localparam int K_PINS = 2;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    logic chk_vld = 1'b0;
    logic done = 1'b0;
    logic end_checked = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t cur;
    logic [31:0] act;

    always @(negedge clk) begin
        if (chk_vld) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL monitor: check requested with empty scoreboard");
            end else begin
                cur = sb.pop_front();
                case (cur.kind)
                    K_IRQ:   act = {31'b0, irq};
                    K_PINS:  act = {24'b0, pins};
                    default: act = dout;
                endcase
                if (act !== cur.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", cur.name, act, cur.exp);
                end
            end
        end
        if (done && !end_checked) begin
            end_checked <= 1'b1;
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        addr = a;
        di   = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic chk(input int kind, input logic [2:0] a, input logic [31:0] e, input string nm);
        exp_t x;
        x.kind = kind;
        x.exp  = e;
        x.name = nm;
        addr = a;
        sb.push_back(x);
        chk_vld = 1'b1;
        @(negedge clk);
        #1;
        chk_vld = 1'b0;
    endtask

    initial begin
        // Reset with garbage writes on the bus
        for (int i = 0; i < 4; i++) begin
            addr = 3'(i);
            di   = 32'hDEAD_BEEF ^ 32'(i);
            we   = 1'b1;
            tick();
        end
        we    = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) chk(K_DOUT, 3'(i), 32'h0, $sformatf("reset_reg%0d", i));
        chk(K_IRQ, 3'd0, 32'h0, "reset_irq");

        // Output path; external drives 0x5 on the high nibble, complement of DUT's 0xA
        ext_en  = 8'hF0;
        ext_drv = 8'h50;
        wr(3'd1, 32'h0F);
        wr(3'd0, 32'hA5);
        chk(K_PINS, 3'd0, 32'h55, "out_pins");
        chk(K_DOUT, 3'd0, 32'hA5, "out_data");
        wr(3'd6, 32'h0A);
        chk(K_DOUT, 3'd0, 32'hAF, "set");
        wr(3'd7, 32'h05);
        chk(K_DOUT, 3'd0, 32'hAA, "clr");
        wr(3'd6, 32'h01);
        wr(3'd7, 32'h01);
        chk(K_DOUT, 3'd0, 32'hAA, "set_clr_b2b");
        chk(K_PINS, 3'd0, 32'h5A, "out_pins2");
        chk(K_DOUT, 3'd6, 32'h0, "read_set");
        chk(K_DOUT, 3'd7, 32'h0, "read_clr");
        wr(3'd1, 32'hFFFF_FF00);
        chk(K_DOUT, 3'd1, 32'h0, "dir_hi_ignored");
        wr(3'd0, 32'hFFFF_FFFF);
        chk(K_DOUT, 3'd0, 32'hFF, "data_hi_ignored");

        // Input synchroniser latency
        ext_en  = 8'hFF;
        ext_drv = 8'h00;
        repeat (4) tick();
        ext_drv = 8'h3C;
        tick();
        chk(K_DOUT, 3'd2, 32'h00, "sync_t1");
        chk(K_DOUT, 3'd2, 32'h3C, "sync_t2");

        // Rising interrupt on pin0
        wr(3'd5, 32'hFF);
        wr(3'd4, 32'h01);
        wr(3'd3, 32'h01);
        tick();
        ext_drv[0] = 1'b1;
        tick();
        tick();
        chk(K_IRQ, 3'd5, 32'h0, "rise_irq_t2");
        chk(K_IRQ, 3'd5, 32'h1, "rise_irq_t3");
        chk(K_DOUT, 3'd5, 32'h01, "rise_status");
        wr(3'd5, 32'h01);
        chk(K_IRQ, 3'd5, 32'h0, "w1c_irq");
        tick();
        ext_drv[0] = 1'b0;
        repeat (4) tick();
        chk(K_DOUT, 3'd5, 32'h00, "fall_ignored");

        // Falling interrupt on pin7, then hit coinciding with W1C
        wr(3'd4, 32'h00);
        ext_drv[7] = 1'b1;
        repeat (4) tick();
        wr(3'd3, 32'h80);
        tick();
        ext_drv[7] = 1'b0;
        repeat (4) tick();
        chk(K_DOUT, 3'd5, 32'h80, "fall_status");
        ext_drv[7] = 1'b1;
        repeat (4) tick();
        chk(K_DOUT, 3'd5, 32'h80, "rise_no_hit");
        tick();
        ext_drv[7] = 1'b0;
        tick();
        tick();
        wr(3'd5, 32'h80);
        chk(K_DOUT, 3'd5, 32'h80, "set_wins");
        chk(K_IRQ, 3'd5, 32'h1, "set_wins_irq");
        wr(3'd5, 32'h80);
        chk(K_DOUT, 3'd5, 32'h00, "fall_cleared");

        // Disabled pin toggles leave no trace
        wr(3'd3, 32'h00);
        tick();
        ext_drv[2] = 1'b0;
        repeat (4) tick();
        ext_drv[2] = 1'b1;
        repeat (4) tick();
        chk(K_DOUT, 3'd5, 32'h00, "disabled_pin");
        wr(3'd3, 32'h04);
        repeat (2) tick();
        chk(K_DOUT, 3'd5, 32'h00, "no_retro");

        // Mid-operation reset with everything pending and driving
        wr(3'd4, 32'hFF);
        wr(3'd3, 32'hFF);
        ext_drv = 8'h00;
        repeat (4) tick();
        wr(3'd5, 32'hFF);
        ext_drv = 8'hFF;
        repeat (4) tick();
        chk(K_DOUT, 3'd5, 32'hFF, "all_status");
        chk(K_IRQ, 3'd5, 32'h1, "all_irq");
        ext_en = 8'h00;
        wr(3'd1, 32'hFF);
        wr(3'd0, 32'h5A);
        chk(K_PINS, 3'd0, 32'h5A, "drive_all");
        reset = 1'b1;
        addr  = 3'd1;
        di    = 32'hFFFF_FFFF;
        we    = 1'b1;
        tick();
        reset = 1'b0;
        we    = 1'b0;
        chk(K_DOUT, 3'd1, 32'h0, "rst_dir");
        chk(K_DOUT, 3'd0, 32'h0, "rst_data");
        chk(K_DOUT, 3'd5, 32'h0, "rst_status");
        chk(K_DOUT, 3'd3, 32'h0, "rst_en");
        chk(K_IRQ, 3'd0, 32'h0, "rst_irq");
        ext_en  = 8'hFF;
        ext_drv = 8'hC3;
        chk(K_PINS, 3'd0, 32'hC3, "rst_pins_z");
        repeat (3) tick();
        chk(K_DOUT, 3'd2, 32'hC3, "rst_data_in");

        done = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
